// File: rtl/harpoon_hit_unit.sv
// rtl/harpoon_hit_unit.sv - harpoon launcher, per-frame advance and ball collision responder
module harpoon_hit_unit #(
  parameter logic [7:0]  FIRE_KEY    = 8'h2C,
  parameter int unsigned FLOOR_Y     = 398,
  parameter int unsigned CEIL_Y      = 250,
  parameter int unsigned BULLET_STEP = 4,
  parameter int unsigned COOLDOWN    = 8,
  parameter int unsigned MIN_SIZE    = 10
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  logic [7:0] keycode4,
  input  logic [1:0] game_on,
  input  logic       ball_inplay,
  input  logic [9:0] player_x,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  output logic       bullet_active,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_top_y,
  output logic       bullet_hit,
  output logic [7:0] hits_total
);

  typedef enum logic [1:0] {IDLE, RISING, COOL} state_t;

  localparam int unsigned CW       = $clog2(COOLDOWN + 1);
  localparam logic [9:0]  FLOOR_V  = 10'(FLOOR_Y);
  localparam logic [9:0]  CEIL_LIM = 10'(CEIL_Y + BULLET_STEP);
  localparam logic [9:0]  STEP_V   = 10'(BULLET_STEP);
  localparam logic [9:0]  MIN_V    = 10'(MIN_SIZE);
  localparam logic [CW-1:0] COOL_V = CW'(COOLDOWN);
  localparam logic [CW-1:0] COOL_1 = CW'(1);

  state_t        state_q;
  logic [CW-1:0] cool_q;
  logic          pressed_prev_q;
  logic          active_q;
  logic [9:0]    x_q;
  logic [9:0]    top_q;
  logic          hit_q;
  logic [7:0]    hits_q;

  logic        pressed;
  logic        fire_edge;
  logic        abort;
  logic [10:0] dx;
  logic [10:0] adx;
  logic [10:0] ball_bottom;
  logic        ball_hit;
  logic        at_ceil;

  // Fire key edge detect, abort condition and circle-vs-harpoon test on the registered tip
  always_comb begin
    pressed     = (keycode == FIRE_KEY) || (keycode2 == FIRE_KEY) ||
                  (keycode3 == FIRE_KEY) || (keycode4 == FIRE_KEY);
    fire_edge   = pressed && !pressed_prev_q;
    abort       = (game_on == 2'b00) || !ball_inplay;
    dx          = {1'b0, BallX} - {1'b0, x_q};
    adx         = dx[10] ? (11'd0 - dx) : dx;
    ball_bottom = {1'b0, BallY} + {1'b0, BallS};
    ball_hit    = (BallS >= MIN_V) && (adx < {1'b0, BallS}) &&
                  (ball_bottom >= {1'b0, top_q});
    at_ceil     = (top_q <= CEIL_LIM);
  end

  // Harpoon FSM: launch, rise one step per frame, retire on hit or ceiling, then cool down
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      cool_q         <= '0;
      pressed_prev_q <= 1'b0;
      active_q       <= 1'b0;
      x_q            <= '0;
      top_q          <= FLOOR_V;
      hit_q          <= 1'b0;
      hits_q         <= '0;
    end else begin
      pressed_prev_q <= pressed;
      if (abort) begin
        state_q  <= IDLE;
        active_q <= 1'b0;
        hit_q    <= 1'b0;
        top_q    <= FLOOR_V;
        cool_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (fire_edge) begin
              x_q      <= player_x;
              top_q    <= FLOOR_V;
              active_q <= 1'b1;
              state_q  <= RISING;
            end
          end
          RISING: begin
            if (ball_hit) begin
              hit_q    <= 1'b1;
              active_q <= 1'b0;
              if (hits_q != 8'hFF) hits_q <= hits_q + 8'd1;
              cool_q   <= COOL_V;
              state_q  <= COOL;
            end else if (at_ceil) begin
              active_q <= 1'b0;
              cool_q   <= COOL_V;
              state_q  <= COOL;
            end else begin
              top_q <= top_q - STEP_V;
            end
          end
          COOL: begin
            hit_q <= 1'b0;
            if (cool_q <= COOL_1) begin
              cool_q  <= '0;
              top_q   <= FLOOR_V;
              state_q <= IDLE;
            end else begin
              cool_q <= cool_q - COOL_1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bullet_active = active_q;
  assign bullet_x      = x_q;
  assign bullet_top_y  = top_q;
  assign bullet_hit    = hit_q;
  assign hits_total    = hits_q;

endmodule

// File: tb/tb_harpoon_hit_unit.sv
// tb/tb_harpoon_hit_unit.sv - self-checking bench for harpoon_hit_unit
module tb_harpoon_hit_unit;

  localparam logic [7:0] FK = 8'h2C;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] keycode = 8'h00, keycode2 = 8'h00, keycode3 = 8'h00, keycode4 = 8'h00;
  logic [1:0] game_on = 2'd1;
  logic       ball_inplay = 1'b1;
  logic [9:0] player_x = 10'd320;
  logic [9:0] BallX = 10'd320, BallY = 10'd300, BallS = 10'd20;
  logic       bullet_active;
  logic [9:0] bullet_x;
  logic [9:0] bullet_top_y;
  logic       bullet_hit;
  logic [7:0] hits_total;

  harpoon_hit_unit dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .keycode(keycode), .keycode2(keycode2), .keycode3(keycode3), .keycode4(keycode4),
    .game_on(game_on), .ball_inplay(ball_inplay), .player_x(player_x),
    .BallX(BallX), .BallY(BallY), .BallS(BallS),
    .bullet_active(bullet_active), .bullet_x(bullet_x), .bullet_top_y(bullet_top_y),
    .bullet_hit(bullet_hit), .hits_total(hits_total)
  );

  always #5 frame_clk = ~frame_clk;

  logic [29:0] sb_q[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [29:0] pk(input logic a, input logic [9:0] x, input logic [9:0] t,
                                     input logic h, input logic [7:0] n);
    return {a, x, t, h, n};
  endfunction

  function automatic logic [29:0] obs();
    return {bullet_active, bullet_x, bullet_top_y, bullet_hit, hits_total};
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [29:0] e;
    #1 Reset = 1'b1;
    sb_q.push_back(pk(1'b0, 10'd0, 10'd398, 1'b0, 8'd0));
    tick();
    e = sb_q.pop_front(); n_vec++;
    if (obs() !== e) begin n_bad++; $display("FAIL reset got %h want %h", obs(), e); end
    Reset = 1'b0;
  endtask

  task automatic test_hit();
    logic [29:0] e;
    player_x = 10'd320; BallX = 10'd320; BallY = 10'd300; BallS = 10'd20;
    for (int k = 0; k <= 29; k++) begin
      keycode = (k < 3) ? FK : 8'h00;
      if (k <= 20)      e = pk(1'b1, 10'd320, 10'(398 - 4 * k), 1'b0, 8'd0);
      else if (k == 21) e = pk(1'b0, 10'd320, 10'd318, 1'b1, 8'd1);
      else if (k <= 28) e = pk(1'b0, 10'd320, 10'd318, 1'b0, 8'd1);
      else              e = pk(1'b0, 10'd320, 10'd398, 1'b0, 8'd1);
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front(); n_vec++;
      if (obs() !== e) begin n_bad++; $display("FAIL hit E%0d got %h want %h", k, obs(), e); end
    end
  endtask

  task automatic test_miss();
    logic [29:0] e;
    BallX = 10'd500;
    for (int k = 0; k <= 58; k++) begin
      keycode3 = (k == 0 || k == 40 || k == 46) ? FK : 8'h00;
      if (k <= 36)      e = pk(1'b1, 10'd320, 10'(398 - 4 * k), 1'b0, 8'd1);
      else if (k <= 44) e = pk(1'b0, 10'd320, 10'd254, 1'b0, 8'd1);
      else if (k == 45) e = pk(1'b0, 10'd320, 10'd398, 1'b0, 8'd1);
      else              e = pk(1'b1, 10'd320, 10'(398 - 4 * (k - 46)), 1'b0, 8'd1);
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front(); n_vec++;
      if (obs() !== e) begin n_bad++; $display("FAIL miss E%0d got %h want %h", k, obs(), e); end
    end
    keycode3 = 8'h00;
  endtask

  task automatic test_abort();
    logic [29:0] e;
    for (int k = 0; k < 3; k++) begin
      ball_inplay = (k == 2);
      keycode = (k == 1) ? FK : 8'h00;
      sb_q.push_back(pk(1'b0, 10'd320, 10'd398, 1'b0, 8'd1));
      tick();
      e = sb_q.pop_front(); n_vec++;
      if (obs() !== e) begin n_bad++; $display("FAIL abort f%0d got %h want %h", k, obs(), e); end
    end
    keycode = 8'h00;
  endtask

  task automatic test_held_key();
    logic [29:0] e;
    BallX = 10'd500;
    for (int k = 0; k <= 53; k++) begin
      keycode2 = (k == 51 || k == 53) ? 8'h00 : FK;
      if (k == 52) player_x = 10'd200;
      ball_inplay = (k != 53);
      if (k <= 36)      e = pk(1'b1, 10'd320, 10'(398 - 4 * k), 1'b0, 8'd1);
      else if (k <= 44) e = pk(1'b0, 10'd320, 10'd254, 1'b0, 8'd1);
      else if (k <= 51) e = pk(1'b0, 10'd320, 10'd398, 1'b0, 8'd1);
      else if (k == 52) e = pk(1'b1, 10'd200, 10'd398, 1'b0, 8'd1);
      else              e = pk(1'b0, 10'd200, 10'd398, 1'b0, 8'd1);
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front(); n_vec++;
      if (obs() !== e) begin n_bad++; $display("FAIL held E%0d got %h want %h", k, obs(), e); end
    end
    keycode2 = 8'h00; ball_inplay = 1'b1; player_x = 10'd320;
  endtask

  task automatic test_small_ball();
    logic [29:0] e;
    BallX = 10'd320; BallY = 10'd396; BallS = 10'd5;
    for (int k = 0; k <= 45; k++) begin
      keycode4 = (k == 0) ? FK : 8'h00;
      if (k <= 36)      e = pk(1'b1, 10'd320, 10'(398 - 4 * k), 1'b0, 8'd1);
      else if (k <= 44) e = pk(1'b0, 10'd320, 10'd254, 1'b0, 8'd1);
      else              e = pk(1'b0, 10'd320, 10'd398, 1'b0, 8'd1);
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front(); n_vec++;
      if (obs() !== e) begin n_bad++; $display("FAIL small E%0d got %h want %h", k, obs(), e); end
    end
  endtask

  task automatic test_dx_edge();
    logic [29:0] e;
    BallX = 10'd340; BallY = 10'd396; BallS = 10'd20;
    for (int k = 0; k <= 11; k++) begin
      keycode = (k == 0) ? FK : 8'h00;
      if (k == 3) BallX = 10'd339;
      if (k <= 2)       e = pk(1'b1, 10'd320, 10'(398 - 4 * k), 1'b0, 8'd1);
      else if (k == 3)  e = pk(1'b0, 10'd320, 10'd390, 1'b1, 8'd2);
      else if (k <= 10) e = pk(1'b0, 10'd320, 10'd390, 1'b0, 8'd2);
      else              e = pk(1'b0, 10'd320, 10'd398, 1'b0, 8'd2);
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front(); n_vec++;
      if (obs() !== e) begin n_bad++; $display("FAIL dx_edge E%0d got %h want %h", k, obs(), e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] e;
    BallX = 10'd500; BallS = 10'd20;
    for (int k = 0; k <= 17; k++) begin
      keycode = (k == 0) ? FK : 8'h00;
      sb_q.push_back(pk(1'b1, 10'd320, 10'(398 - 4 * k), 1'b0, 8'd2));
      tick();
      e = sb_q.pop_front(); n_vec++;
      if (obs() !== e) begin n_bad++; $display("FAIL rst_mid E%0d got %h want %h", k, obs(), e); end
    end
    #2 Reset = 1'b1;
    sb_q.push_back(pk(1'b0, 10'd0, 10'd398, 1'b0, 8'd0));
    #1;
    e = sb_q.pop_front(); n_vec++;
    if (obs() !== e) begin n_bad++; $display("FAIL rst_async got %h want %h", obs(), e); end
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_saturate();
    logic [29:0] e;
    player_x = 10'd320; BallX = 10'd305; BallY = 10'd390; BallS = 10'd20;
    for (int i = 1; i <= 256; i++) begin
      keycode = FK;
      tick();
      keycode = 8'h00;
      sb_q.push_back(pk(1'b0, 10'd320, 10'd398, 1'b1, (i > 255) ? 8'd255 : 8'(i)));
      tick();
      e = sb_q.pop_front(); n_vec++;
      if (obs() !== e) begin n_bad++; $display("FAIL sat hit%0d got %h want %h", i, obs(), e); end
      for (int c = 0; c < 8; c++) tick();
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_abort();
    test_held_key();
    test_small_ball();
    test_dx_edge();
    test_reset_mid();
    test_saturate();
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard leftover got %0d want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
